adc_buf_reader: RTL

ADC_BUF_READER -- requirements
Module: adc_buf_reader

---
 rtl/adc_buf_pkg.sv | 7 +
 rtl/sync_fifo2.sv | 40 ++++
 rtl/adc_buf_reader.sv | 108 ++++++++++
 3 files changed

// File: rtl/adc_buf_pkg.sv
// adc_buf_pkg: constants and reader state type shared by the ADC buffer writer and reader
package adc_buf_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    localparam int HALF_WORDS = 32768;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/sync_fifo2.sv
// sync_fifo2: 2-entry first-word-fall-through FIFO
// ports: clk, rst (sync, active-high), push/din write side, pop/dout read side
// (dout valid whenever empty is low), full/empty occupancy flags
module sync_fifo2
    import adc_buf_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wp, rp, do_push, do_pop;
    logic [1:0]   cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = cnt == 2'd2;
    assign empty   = cnt == 2'd0;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            wp  <= wp ^ do_push;
            rp  <= rp ^ do_pop;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/adc_buf_reader.sv
// adc_buf_reader: reads each completed ping-pong half of the ADC BRAM and streams it to the host DMA
// ports: clk, reset (sync, active-high); wr_half writer's current half; cfg_len words per block (0 = off);
// ovr_clr clears sticky overrun; bram_rd_en/bram_rd_addr/bram_rd_dout BRAM read port (1-cycle latency);
// m_data/m_valid/m_ready/m_last output stream; user_int_o block-done pulse; busy; overrun; blk_count
module adc_buf_reader #(
    parameter int ADDR_W     = adc_buf_pkg::ADDR_W,
    parameter int DATA_W     = adc_buf_pkg::DATA_W,
    parameter int HALF_WORDS = adc_buf_pkg::HALF_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_half,
    input  logic [31:0]       cfg_len,
    input  logic              ovr_clr,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              user_int_o,
    output logic              busy,
    output logic              overrun,
    output logic [31:0]       blk_count
);
    import adc_buf_pkg::*;
    state_t            state, nxt;
    logic              wr_q, wr_p, evt, idle, start, start_half, pend, pend_half;
    logic              infl, infl_last, last_rd, pop, done, ovr_set;
    logic              fifo_full, fifo_empty, fifo_last;
    logic [1:0]        occ;
    logic [31:0]       len_q, cnt_q, eff_len;
    logic [ADDR_W-1:0] addr_q;
    assign evt        = (wr_q != wr_p) && (cfg_len != 32'd0);
    assign idle       = state == IDLE;
    assign busy       = !idle;
    assign start      = idle && (cfg_len != 32'd0) && (pend || evt);
    assign start_half = pend ? pend_half : wr_p;
    assign eff_len    = cfg_len > 32'(HALF_WORDS) ? 32'(HALF_WORDS) : cfg_len;
    assign occ        = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
    assign m_valid    = !fifo_empty;
    assign m_last     = m_valid && fifo_last;
    assign pop        = m_valid && m_ready;
    assign done       = pop && m_last;
    assign last_rd    = cnt_q == len_q - 32'd1;
    assign ovr_set    = evt && busy && pend;
    // a beat leaving this cycle frees a slot, which keeps reads back-to-back at full rate
    assign bram_rd_en   = (state == RUN) && ({1'b0, occ} + {2'b0, infl} < 3'd2 + {2'b0, pop});
    assign bram_rd_addr = addr_q;
    always_comb begin
        nxt = state;
        nxt = idle ? (start ? RUN : IDLE)
            : state == RUN ? (bram_rd_en && last_rd ? DRAIN : RUN)
            : (done ? IDLE : DRAIN);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_q       <= wr_half;
            wr_p       <= wr_half;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            infl       <= 1'b0;
            infl_last  <= 1'b0;
            pend       <= 1'b0;
            pend_half  <= 1'b0;
            overrun    <= 1'b0;
            user_int_o <= 1'b0;
            blk_count  <= '0;
        end else begin
            state <= nxt;
            wr_q  <= wr_half;
            wr_p  <= wr_q;
            if (start) begin
                len_q  <= eff_len;
                cnt_q  <= '0;
                addr_q <= start_half ? ADDR_W'(HALF_WORDS) : '0;
            end else if (bram_rd_en) begin
                cnt_q <= cnt_q + 32'd1;
                if (!last_rd) addr_q <= addr_q + 1'b1;
            end
            infl      <= bram_rd_en;
            infl_last <= bram_rd_en && last_rd;
            // an event landing while IDLE with a pending block re-fills the slot that start consumes
            if (evt && (busy || pend) && !ovr_set) begin
                pend      <= 1'b1;
                pend_half <= wr_p;
            end else if (start && pend) begin
                pend <= 1'b0;
            end
            overrun    <= ovr_set || (overrun && !ovr_clr);
            user_int_o <= done;
            blk_count  <= blk_count + 32'(done);
        end
    end
    sync_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (infl),
        .din   ({infl_last, bram_rd_dout}),
        .pop   (pop),
        .dout  ({fifo_last, m_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule
